sram_request_scheduler: RTL
===========================

// Module: sram_request_scheduler
// PURPOSE
//  Single-clock scheduler sharing one SRAM command port between two write requesters (w0, w1)
//  and two read requesters (r0, r1). Grants round-robin in order w0,w1,r0,r1 and issues one
//  registered command per grant. Read returns are routed back to their requester by tag. Sits
//  between the per-port request FIFOs (already in sram_clock domain) and the SRAM controller.
// PARAMETERS
//  ADDR_W           19  SRAM word address width
//  DATA_W           32  SRAM data width
//  MASK_W            4  write byte-mask width; mask==0 encodes a read
//  MAX_OUTSTANDING   4  max in-flight reads per read port
//  TAG_DEPTH         8  return-tag FIFO depth (power of 2, >= 2*MAX_OUTSTANDING)
// PORTS
//  sram_clock          in   1            sole clock
//  reset_n             in   1            asynchronous, active-low reset
//  req_valid           in   4            [0]=w0 [1]=w1 [2]=r0 [3]=r1 request present
//  req_ready           out  4            one-hot grant; request consumed this cycle
//  req_addr            in   4*ADDR_W     per-port address, port i at [i*ADDR_W +: ADDR_W]
//  req_wdata           in   2*DATA_W     write data for w0/w1
//  req_mask            in   2*MASK_W     write mask for w0/w1 (must be nonzero)
//  rd_space            in   2            r0/r1 return FIFO can accept MAX_OUTSTANDING words (i.e. !prog_full)
//  rd_dout_valid       out  2            return word valid for r0/r1 (never both)
//  rd_dout             out  DATA_W       return data, shared bus
//  sram_addr_valid     out  1            command valid
//  sram_ready          in   1            SRAM accepts command
//  sram_addr           out  ADDR_W       command address
//  sram_write_mask     out  MASK_W       0 = read
//  sram_data_in        out  DATA_W       write data
//  sram_data_out       in   DATA_W       read data from SRAM
//  sram_data_out_valid in   1            read data valid, in issue order
//  state               out  2            index of last granted port
//  tag_err             out  1            sticky: return arrived with no outstanding tag
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer=0 (w0); counters and tag FIFO empty; tag_err=0.
//  Command slot loads when !sram_addr_valid || sram_ready ("load").
//  Eligible(i): writes: req_valid[i]. reads: req_valid[i] & rd_space[i-2] & outst[i-2]<MAX_OUTSTANDING
//    & tag FIFO not full.
//  On load: grant g = first eligible port scanning from pointer, wrapping 3->0; req_ready[g]=1
//    combinationally that cycle; slot registers addr/mask/data next edge; pointer<=g+1 mod 4;
//    state<=g. No eligible port: slot empties (sram_addr_valid<=0), pointer and state hold.
//  Latency: req_valid to sram_addr_valid = 1 cycle; full throughput 1 command/cycle while sram_ready=1.
//  sram_ready=0: slot holds all command outputs stable; req_ready all 0.
//  Read accepted (sram_addr_valid & sram_ready & mask==0): push port id to tag FIFO; outst[p]++.
//  sram_data_out_valid: pop tag t; next cycle rd_dout_valid[t]=1, rd_dout=data; outst[t]--.
//  Same-cycle accept and return on one port: outst unchanged. Same-cycle push/pop on full FIFO: legal.
//  Return with tag FIFO empty: data dropped, tag_err<=1 until reset (covers reads in flight at reset).
//  reset_n low mid-operation: command dropped, in-flight tags discarded, pointer back to w0.
// CONFIGURATION
//  SRAM_SCHED_STATS_EN defined: extra output grant_count (out, 4*16): per-port saturating grant
//    counters (hold at 16'hFFFF), increment on req_ready[i], cleared by reset.
//  Undefined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  sram_sched_pkg: port index constants (PORT_W0..PORT_R1), READ_MASK=0, tag width localparam.
//  Sub-module sram_sched_tag_fifo: TAG_DEPTH x 1-bit sync FIFO (push, pop, full, empty).
// TESTING
//  All 4 req_valid=1, sram_ready=1, rd_space=2'b11 -> state cycles 0,1,2,3,0,1,2,3 on consecutive cycles.
//  Only r1 valid after w0 grant -> next grant r1 (state=3), pointer then wraps to w0.
//  r0,r1 valid, rd_space=0 for 64 cycles -> req_ready[3:2]=0, sram_addr_valid=0 throughout.
//  sram_ready=0 for 5 cycles with w1 pending -> sram_addr/mask/data stable, req_ready=0; issues on release.
//  r0 issues 4 reads, no returns -> 5th r0 request stalls; one return -> r0 issues again;
//    returns ordered r0,r1 -> rd_dout_valid 2'b01 then 2'b10.
//  sram_data_out_valid with no reads outstanding -> rd_dout_valid=0, tag_err=1 stays set.

Source files
------------

// File: rtl/sram_sched_pkg.sv
// Shared constants and types for the SRAM request scheduler.
package sram_sched_pkg;

    localparam int NUM_PORTS = 4;
    localparam int READ_MASK = 0;
    localparam int TAG_W     = 1;

    typedef enum logic [1:0] {
        PORT_W0 = 2'd0,
        PORT_W1 = 2'd1,
        PORT_R0 = 2'd2,
        PORT_R1 = 2'd3
    } port_e;

endpackage

// File: rtl/sram_request_scheduler_if.sv
// Requester-side and SRAM-side handshake signals of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface sram_request_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic [3:0]          req_valid;
    logic [3:0]          req_ready;
    logic [4*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*MASK_W-1:0] req_mask;
    logic [1:0]          rd_space;
    logic [1:0]          rd_dout_valid;
    logic [DATA_W-1:0]   rd_dout;
    logic                sram_addr_valid;
    logic                sram_ready;
    logic [ADDR_W-1:0]   sram_addr;
    logic [MASK_W-1:0]   sram_write_mask;
    logic [DATA_W-1:0]   sram_data_in;
    logic [DATA_W-1:0]   sram_data_out;
    logic                sram_data_out_valid;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_mask, rd_space,
        input  sram_ready, sram_data_out, sram_data_out_valid,
        output req_ready, rd_dout_valid, rd_dout,
        output sram_addr_valid, sram_addr, sram_write_mask, sram_data_in
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_mask, rd_space,
        output sram_ready, sram_data_out, sram_data_out_valid,
        input  req_ready, rd_dout_valid, rd_dout,
        input  sram_addr_valid, sram_addr, sram_write_mask, sram_data_in
    );
endinterface

// File: rtl/sram_sched_tag_fifo.sv
// Return-tag FIFO: records which read port issued each accepted read, in issue order.
module sram_sched_tag_fifo
    import sram_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             sram_clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-on-full with pop is accepted.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge sram_clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/sram_request_scheduler.sv
// Round-robin scheduler (w0,w1,r0,r1) onto one registered SRAM command slot, with tag-routed
// read returns. Define SRAM_SCHED_STATS_EN to add saturating per-port grant counters.
module sram_request_scheduler
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W          = 19,
    parameter int DATA_W          = 32,
    parameter int MASK_W          = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_DEPTH       = 8
) (
    input  logic                      sram_clock,
    input  logic                      reset_n,
    sram_request_scheduler_if.slave   bus,
    output logic [1:0]                state,
    output logic                      tag_err
`ifdef SRAM_SCHED_STATS_EN
    ,
    output logic [4*16-1:0]           grant_count
`endif
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                 load, found;
    logic [NUM_PORTS-1:0] elig, req_ready;
    logic [1:0]           grant, ptr_q, ptr_d;
    port_e                state_q, state_d;
    logic                 av_q, av_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [MASK_W-1:0]    mask_q, mask_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [OUT_W-1:0]     outst_q [2];
    logic [OUT_W-1:0]     outst_d [2];
    logic [OUT_W:0]       pend [2];
    logic                 push, pop, tag_full, tag_empty;
    logic [TAG_W-1:0]     push_tag, tag_head;
    logic [1:0]           rdv_q, rdv_d;
    logic [DATA_W-1:0]    rdout_q, rdout_d;
    logic                 tag_err_q, tag_err_d;

    assign load = !av_q || bus.sram_ready;

    // A read sitting in the slot is counted as in flight so a port can never exceed its limit.
    always_comb begin
        elig[0] = bus.req_valid[0];
        elig[1] = bus.req_valid[1];
        for (int r = 0; r < 2; r++) begin
            pend[r] = {1'b0, outst_q[r]}
                    + (OUT_W+1)'(av_q && (state_q == port_e'(2'(2 + r))));
            elig[2+r] = bus.req_valid[2+r] && bus.rd_space[r]
                      && (pend[r] < (OUT_W+1)'(MAX_OUTSTANDING)) && !tag_full;
        end
    end

    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && elig[ptr_q + 2'(k)]) begin
                grant = ptr_q + 2'(k);
                found = 1'b1;
            end
        end
        req_ready = (load && found) ? (NUM_PORTS'(1) << grant) : '0;
    end

    always_comb begin
        av_d    = av_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        state_d = state_q;
        if (load) begin
            if (found) begin
                av_d    = 1'b1;
                addr_d  = bus.req_addr[grant*ADDR_W +: ADDR_W];
                ptr_d   = grant + 2'd1;
                state_d = port_e'(grant);
                if (grant[1]) begin
                    mask_d = MASK_W'(READ_MASK);
                    data_d = '0;
                end else begin
                    mask_d = bus.req_mask[grant[0]*MASK_W +: MASK_W];
                    data_d = bus.req_wdata[grant[0]*DATA_W +: DATA_W];
                end
            end else begin
                av_d = 1'b0;
            end
        end
    end

    assign push     = av_q && bus.sram_ready && (mask_q == MASK_W'(READ_MASK));
    assign push_tag = TAG_W'(state_q == PORT_R1);
    assign pop      = bus.sram_data_out_valid && !tag_empty;

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            outst_d[r] = outst_q[r]
                       + OUT_W'(push && (push_tag == TAG_W'(r)))
                       - OUT_W'(pop && (tag_head == TAG_W'(r)));
        end
        rdv_d     = pop ? (2'b01 << tag_head) : 2'b00;
        rdout_d   = pop ? bus.sram_data_out : rdout_q;
        tag_err_d = tag_err_q || (bus.sram_data_out_valid && tag_empty);
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            av_q      <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            ptr_q     <= 2'd0;
            state_q   <= PORT_W0;
            outst_q   <= '{default: '0};
            rdv_q     <= '0;
            rdout_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            av_q      <= av_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            state_q   <= state_d;
            outst_q   <= outst_d;
            rdv_q     <= rdv_d;
            rdout_q   <= rdout_d;
            tag_err_q <= tag_err_d;
        end
    end

    sram_sched_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .sram_clock  (sram_clock),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_tag),
        .pop_i       (pop),
        .pop_data_o  (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    assign bus.req_ready       = req_ready;
    assign bus.sram_addr_valid = av_q;
    assign bus.sram_addr       = addr_q;
    assign bus.sram_write_mask = mask_q;
    assign bus.sram_data_in    = data_q;
    assign bus.rd_dout_valid   = rdv_q;
    assign bus.rd_dout         = rdout_q;
    assign state               = state_q;
    assign tag_err             = tag_err_q;

`ifdef SRAM_SCHED_STATS_EN
    logic [15:0] gcnt_q [NUM_PORTS];

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            gcnt_q <= '{default: '0};
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_ready[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign grant_count[g*16 +: 16] = gcnt_q[g];
    end
`endif
endmodule
